fetch_seq_ctrl: RTL
===================

Name: fetch_seq_ctrl

Overview:
Multi-cycle fetch sequencer that owns the PC register's write enable and next-PC value. Each cycle it does one of three things: issues an instruction-memory request, holds the fetched instruction for decode/execute, or redirects on branch/jump. It sits between the PC register, the instruction memory port and the decode/execute stage, and is the only driver of PCWr and NPC.

Parameters:
TRAP_VEC, 32'h0000_0100, NPC substituted for misaligned redirect targets (and fetch timeout when enabled)
TIMEOUT, 16, max cycles waiting for imem_ready (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
PC  in  32  current PC from the PC register
PCWr  out  1  PC write enable
NPC  out  32  next PC value
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address, always equal to PC
imem_ready  in  1  one-cycle response strobe; rdata valid in the same cycle
imem_rdata  in  32  fetched instruction
ir_out  out  32  held instruction
ir_valid  out  1  ir_out valid for decode
ir_ack  in  1  decode/execute consumes the instruction
stall  in  1  blocks instruction retirement
redirect_valid  in  1  branch/jump taken strobe
redirect_target  in  32  branch/jump target
halt_req  in  1  enter halt after the current instruction retires
resume  in  1  leave halt
halted  out  1  high in S_HALT
misalign_err  out  1  misaligned redirect replaced by TRAP_VEC
fetch_fault  out  1  fetch timeout (tied 0 without the macro)

Behaviour:
- States: S_BOOT, S_FETCH, S_HOLD, S_HALT. 2-bit registered state.
- Reset (async, any state, including mid-fetch) forces these values:
  - state=S_BOOT
  - ir_out=0, ir_valid=0, halted=0
  - redirect pending flag redir_pend=0, redir_tgt=0
  - combinational outputs: PCWr=0, imem_req=0, misalign_err=0
  - Any in-flight imem response is ignored.
- S_BOOT: lasts 1 cycle, no outputs active, then S_FETCH.
- S_FETCH: imem_req=1, imem_addr=PC, held until imem_ready.
  - On imem_ready with no redirect pending and no redirect_valid this cycle: latch imem_rdata into ir_out, set ir_valid, go to S_HOLD. PCWr stays 0.
  - On imem_ready with redir_pend or redirect_valid: discard the instruction (ir_valid stays 0). Assert PCWr=1 with NPC=target (redirect_valid takes priority over redir_pend). Clear redir_pend and stay in S_FETCH; the next cycle requests from the new PC.
- redirect_valid in any cycle not consumed as above: latch into redir_pend/redir_tgt. The latest redirect wins.
- S_HOLD: ir_valid=1, ir_out stable.
  - Retire condition: ir_ack=1 and stall=0.
  - On retire, assert PCWr=1. NPC is chosen by priority: redirect_valid ? redirect_target : redir_pend ? redir_tgt : PC+4 (mod 2^32).
  - Also on retire: clear redir_pend and ir_valid. Go to S_HALT if halt_req, else S_FETCH.
  - With stall=1, ir_ack is ignored; no PCWr, state holds.
- S_HALT: halted=1, imem_req=0, PCWr=0. resume goes to S_FETCH. Redirects arriving in S_HALT are still latched.
- Latency: a memory with zero wait states gives 2 cycles per instruction (fetch cycle plus hold cycle with ack).
- Misalignment: whenever the selected NPC comes from a redirect with target[1:0]!=0, NPC=TRAP_VEC and misalign_err=1 in that PCWr cycle.
- PCWr, NPC, imem_req and misalign_err are combinational from state/inputs. PC updates at the clock edge ending the PCWr cycle.
- imem_ready outside S_FETCH is ignored.

Optional Feature:
FETCH_TIMEOUT_EN:
- Defined: a wait counter increments each S_FETCH cycle without imem_ready and clears on leaving S_FETCH. When it reaches TIMEOUT-1 without ready, the controller asserts PCWr with NPC=TRAP_VEC and fetch_fault=1 for that one cycle, clears redir_pend, and stays in S_FETCH.
- Not defined: no counter, fetch_fault tied to 0, and S_FETCH waits indefinitely.

Test Plan:
1. Reset release, PC=0, imem_ready on the 2nd S_FETCH cycle with rdata 0x00500093 -> ir_valid=1, ir_out=0x00500093. Then ir_ack -> PCWr=1 for one cycle, NPC=0x4, next imem_addr=0x4.
2. redirect_valid with target 0x40 during an S_FETCH wait, ready arrives 2 cycles later -> ir_valid stays 0, PCWr=1, NPC=0x40, following imem_addr=0x40.
3. In S_HOLD with redir_pend=0x40, ir_ack coincides with redirect_valid=0x80 -> NPC=0x80, redir_pend cleared.
4. ir_ack held while stall=1 for 3 cycles -> no PCWr and ir_out stable. stall drops -> single PCWr, NPC=PC+4. With PC=0xFFFFFFFC -> NPC=0x0.
5. Redirect target 0x42 at retire -> NPC=0x100, misalign_err=1 for one cycle. Separately, halt_req at retire -> halted=1, no imem_req until resume.
6. With FETCH_TIMEOUT_EN and imem_ready never asserted -> after 16 S_FETCH cycles PCWr=1, NPC=0x100, fetch_fault=1. Assert rst mid-fetch -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: multi-cycle fetch sequencer.
// Sole owner of the PC register write enable (PCWr) and next-PC value (NPC).
// It alternates between requesting an instruction, holding it for decode and
// redirecting on branches. Redirects that cannot be honoured immediately are
// parked in a one-entry pending slot, and the most recent redirect wins.
// Optional macro FETCH_TIMEOUT_EN adds a bounded wait on imem_ready that traps
// to TRAP_VEC. When the macro is absent, fetch_fault is tied low.
module fetch_seq_ctrl #(
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC,
   output logic        PCWr,
   output logic [31:0] NPC,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir_out,
   output logic        ir_valid,
   input  logic        ir_ack,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        halt_req,
   input  logic        resume,
   output logic        halted,
   output logic        misalign_err,
   output logic        fetch_fault
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] ir_out_q, ir_out_d;
   logic        ir_valid_q, ir_valid_d;
   logic        redir_pend_q, redir_pend_d;
   logic [31:0] redir_tgt_q, redir_tgt_d;

   logic        redir_any;
   logic [31:0] redir_sel;
   logic        retire;
   logic        rv_consumed;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned      CNT_W    = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_hit;
`endif

   // Misaligned redirect targets are replaced by the trap vector.
   function automatic logic [31:0] redirect_npc(input logic [31:0] tgt);
      return (tgt[1:0] != 2'b00) ? TRAP_VEC : tgt;
   endfunction

   function automatic logic redirect_misaligned(input logic [31:0] tgt);
      return (tgt[1:0] != 2'b00);
   endfunction

   // Next-state, PC-write and fetch-request decode.
   always_comb begin
      state_d      = state_q;
      ir_out_d     = ir_out_q;
      ir_valid_d   = ir_valid_q;
      redir_pend_d = redir_pend_q;
      redir_tgt_d  = redir_tgt_q;
      PCWr         = 1'b0;
      NPC          = PC + 32'd4;
      imem_req     = 1'b0;
      misalign_err = 1'b0;
      rv_consumed  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      timeout_hit  = 1'b0;
`endif

      // A redirect presented this cycle outranks one parked earlier.
      redir_any = redirect_valid | redir_pend_q;
      redir_sel = redirect_valid ? redirect_target : redir_tgt_q;
      retire    = ir_ack & ~stall;

      case (state_q)
         S_BOOT: begin
            state_d = S_FETCH;
         end

         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               if (redir_any) begin
                  // The instruction just fetched is on the wrong path: drop it
                  // and restart the fetch from the redirect target.
                  PCWr         = 1'b1;
                  NPC          = redirect_npc(redir_sel);
                  misalign_err = redirect_misaligned(redir_sel);
                  redir_pend_d = 1'b0;
                  rv_consumed  = redirect_valid;
               end else begin
                  ir_out_d   = imem_rdata;
                  ir_valid_d = 1'b1;
                  state_d    = S_HOLD;
               end
            end
`ifdef FETCH_TIMEOUT_EN
            else if (wait_cnt_q == CNT_LAST) begin
               timeout_hit  = 1'b1;
               PCWr         = 1'b1;
               NPC          = TRAP_VEC;
               redir_pend_d = 1'b0;
            end
`endif
         end

         S_HOLD: begin
            if (retire) begin
               PCWr = 1'b1;
               if (redir_any) begin
                  NPC          = redirect_npc(redir_sel);
                  misalign_err = redirect_misaligned(redir_sel);
                  rv_consumed  = redirect_valid;
               end
               redir_pend_d = 1'b0;
               ir_valid_d   = 1'b0;
               state_d      = halt_req ? S_HALT : S_FETCH;
            end
         end

         S_HALT: begin
            if (resume) begin
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_BOOT;
         end
      endcase

      // Any redirect not acted on this cycle is parked; the newest one replaces older ones.
      if (redirect_valid && !rv_consumed) begin
         redir_pend_d = 1'b1;
         redir_tgt_d  = redirect_target;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   // Count fetch cycles spent waiting for a response; any response or trap restarts the count.
   always_comb begin
      wait_cnt_d = '0;
      if ((state_q == S_FETCH) && !imem_ready && !timeout_hit) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
   end

   // Wait counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign fetch_fault = timeout_hit;
`else
   assign fetch_fault = 1'b0;
`endif

   // State, held instruction and pending-redirect registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_BOOT;
         ir_out_q     <= '0;
         ir_valid_q   <= 1'b0;
         redir_pend_q <= 1'b0;
         redir_tgt_q  <= '0;
      end else begin
         state_q      <= state_d;
         ir_out_q     <= ir_out_d;
         ir_valid_q   <= ir_valid_d;
         redir_pend_q <= redir_pend_d;
         redir_tgt_q  <= redir_tgt_d;
      end
   end

   assign imem_addr = PC;
   assign ir_out    = ir_out_q;
   assign ir_valid  = ir_valid_q;
   assign halted    = (state_q == S_HALT);

endmodule
